seven_seg_scan: RTL and testbench



---
 rtl/seg7_pkg.sv | 25 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/seven_seg_scan.sv | 112 +++++++++++
 tb/tb_seven_seg_scan.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan slice.
// Segment patterns are active-high, bit order g..a.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NIB_W      = 4;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high segment decoder.
// Non-BCD nibbles show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// 4-digit multiplexed seven-segment scanner with dead-time,
// leading-zero blanking and a per-scan input snapshot.
module seven_seg_scan
  import seg7_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 100,
  parameter int LZ_BLANK     = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [15:0]           digits,
  input  logic [NUM_DIGITS-1:0] dp_en,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  scan_done
);

  localparam int SLOT_CYCLES = CLK_HZ / REFRESH_HZ;
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [NUM_DIGITS-1:0][NIB_W-1:0] snap_dig;
  logic [NUM_DIGITS-1:0] snap_dp;

  phase_t phase;
  logic [NUM_DIGITS-1:0] lz;
  logic [6:0] dec;
  logic [NUM_DIGITS-1:0] an_hi;
  logic [6:0] seg_hi;
  logic dp_hi;
  logic done_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= '0;
      snap_dig <= '0;
      snap_dp  <= '0;
    end else if (!enable) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (cnt == '0 && idx == 2'd0) begin
        snap_dig <= digits;
        snap_dp  <= dp_en;
      end
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // A digit blanks only when it and every higher digit are zero.
  always_comb begin
    lz = '0;
    if (LZ_BLANK != 0) begin
      lz[3] = (snap_dig[3] == '0);
      lz[2] = lz[3] && (snap_dig[2] == '0);
      lz[1] = lz[2] && (snap_dig[1] == '0);
    end
  end

  bcd_to_seg7 u_dec (
    .nib (snap_dig[idx]),
    .seg (dec)
  );

  always_comb begin
    an_hi   = '0;
    seg_hi  = '0;
    dp_hi   = 1'b0;
    done_hi = (idx == 2'd3) && (cnt == CNT_MAX);
    phase   = (cnt < BLANK_END) ? PH_BLANK : PH_DRIVE;
    unique case (phase)
      PH_BLANK: begin
        an_hi = '0;
      end
      PH_DRIVE: begin
        if (!lz[idx] || snap_dp[idx]) an_hi[idx] = 1'b1;
        if (!lz[idx]) seg_hi = dec;
        dp_hi = snap_dp[idx];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      an        <= {NUM_DIGITS{INV}};
      seg       <= {7{INV}};
      dp        <= INV;
      scan_done <= 1'b0;
    end else begin
      an        <= an_hi ^ {NUM_DIGITS{INV}};
      seg       <= seg_hi ^ {7{INV}};
      dp        <= dp_hi ^ INV;
      scan_done <= done_hi;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: 10-clock slots, 2-clock
// dead time, active-low outputs, leading-zero blanking on.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        scan_done;

  int total = 0;
  int bad = 0;
  int multi_an = 0;

  localparam logic [6:0] L0 = 7'b1000000;
  localparam logic [6:0] L1 = 7'b1111001;
  localparam logic [6:0] L2 = 7'b0100100;
  localparam logic [6:0] L3 = 7'b0110000;
  localparam logic [6:0] L4 = 7'b0011001;
  localparam logic [6:0] L5 = 7'b0010010;
  localparam logic [6:0] L6 = 7'b0000010;
  localparam logic [6:0] L7 = 7'b1111000;
  localparam logic [6:0] L8 = 7'b0000000;
  localparam logic [6:0] LD = 7'b0111111;
  localparam logic [6:0] OFF = 7'b1111111;

  seven_seg_scan #(
    .CLK_HZ       (1000),
    .REFRESH_HZ   (100),
    .BLANK_CYCLES (2),
    .LZ_BLANK     (1),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .digits    (digits),
    .dp_en     (dp_en),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ($countones(~an) > 1) multi_an++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_off(input string tag);
    chk({tag, " an"}, 32'(an), 32'hF);
    chk({tag, " seg"}, 32'(seg), 32'(OFF));
    chk({tag, " dp"}, 32'(dp), 32'd1);
    chk({tag, " done"}, 32'(scan_done), 32'd0);
  endtask

  // One 40-clock scan; s holds expected segs {d3,d2,d1,d0}.
  task automatic scan(input string tag, input logic [3:0][6:0] s,
                      input logic [3:0] anm, input logic [3:0] dpm,
                      input int chg_at, input logic [15:0] nd);
    for (int p = 0; p < 40; p++) begin
      int i;
      bit drv;
      logic [3:0] ea;
      i = p / 10;
      drv = (p % 10) >= 2;
      ea = (drv && anm[i]) ? ~(4'b0001 << i) : 4'hF;
      step(1);
      chk($sformatf("%s p%0d an", tag, p), 32'(an), 32'(ea));
      chk($sformatf("%s p%0d seg", tag, p), 32'(seg),
          32'(drv ? s[i] : OFF));
      chk($sformatf("%s p%0d dp", tag, p), 32'(dp),
          32'(!(drv && dpm[i])));
      chk($sformatf("%s p%0d done", tag, p), 32'(scan_done),
          32'(p == 39));
      if (p == chg_at) digits = nd;
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    digits = 16'h0042;
    dp_en = 4'b0000;
    step(3);
    chk_off("reset");
    reset = 1'b0;

    scan("t1", {OFF, OFF, L4, L2}, 4'b0011, 4'b0000, -1, 16'h0);

    digits = 16'h0000;
    scan("t2a", {OFF, OFF, OFF, L0}, 4'b0001, 4'b0000, -1, 16'h0);
    scan("t2b", {OFF, OFF, OFF, L0}, 4'b0001, 4'b0000, -1, 16'h0);

    digits = 16'h00A5;
    scan("t3", {OFF, OFF, LD, L5}, 4'b0011, 4'b0000, -1, 16'h0);

    digits = 16'h0007;
    dp_en = 4'b0100;
    scan("dp", {OFF, OFF, OFF, L7}, 4'b0101, 4'b0100, -1, 16'h0);

    digits = 16'h1234;
    dp_en = 4'b0000;
    scan("t4a", {L1, L2, L3, L4}, 4'b1111, 4'b0000, 25, 16'h5678);
    scan("t4b", {L5, L6, L7, L8}, 4'b1111, 4'b0000, -1, 16'h0);

    step(13);
    reset = 1'b1;
    step(1);
    chk_off("t6 rst");
    reset = 1'b0;
    scan("t6a", {L5, L6, L7, L8}, 4'b1111, 4'b0000, -1, 16'h0);

    step(13);
    enable = 1'b0;
    digits = 16'h0042;
    step(1);
    chk_off("t6 dis1");
    step(3);
    chk_off("t6 dis2");
    enable = 1'b1;
    scan("t6b", {OFF, OFF, L4, L2}, 4'b0011, 4'b0000, -1, 16'h0);

    chk("one_anode", 32'(multi_an), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
